// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED bank controller: channel mode encodings,
// burst state encodings, the default phase length and a helper that sizes
// the channel-select field.
// -----------------------------------------------------------------------------
package led_pkg;

    // Channel modes as written through the configuration port.
    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_FLASH = 2'd2,
        LED_BURST = 2'd3
    } led_mode_e;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        B_ON  = 2'd0,
        B_OFF = 2'd1,
        B_GAP = 2'd2
    } burst_state_e;

    // Default number of prescaler ticks per blink phase.
    localparam int unsigned LED_PERIOD_DEFAULT = 32'd312500;

    // Width of a channel index; a single-channel bank still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// -----------------------------------------------------------------------------
// led_channel
// One LED channel: holds its own mode/argument and produces a registered
// LED drive from the shared phase pulse.
//
// Ports:
//   i_clk    - system clock
//   i_rst_n  - asynchronous active-low reset
//   i_phase  - one-cycle shared phase pulse from the timebase
//   i_we     - configuration write addressed to this channel
//   i_mode   - mode to write (led_mode_e encoding)
//   i_arg    - blinks per burst (0 behaves as 1)
//   o_led    - registered LED drive, active-high
// -----------------------------------------------------------------------------
module led_channel
    import led_pkg::*;
#(
    parameter int BURST_W    = 4,
    parameter int GAP_PHASES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_phase,
    input  logic               i_we,
    input  logic [1:0]         i_mode,
    input  logic [BURST_W-1:0] i_arg,
    output logic               o_led
);

    localparam int GAP_W = $clog2(GAP_PHASES + 1);

    led_mode_e          mode_q;
    logic [BURST_W-1:0] arg_q;
    burst_state_e       state_q;
    logic [BURST_W-1:0] blink_q;
    logic [GAP_W-1:0]   gap_q;
    logic               restart_q;
    logic               led_q;

    logic [BURST_W-1:0] blink_d;
    logic [GAP_W-1:0]   gap_d;
    logic [BURST_W-1:0] burst_len;
    logic               burst_done;
    logic               gap_done;

    // blink_q stays below burst_len, so the increment cannot wrap.
    assign blink_d    = blink_q + BURST_W'(1);
    assign gap_d      = gap_q + GAP_W'(1);
    assign burst_len  = (arg_q == '0) ? BURST_W'(1) : arg_q;
    assign burst_done = (blink_d >= burst_len);
    assign gap_done   = (gap_d == GAP_W'(GAP_PHASES));

    // A write only latches mode/arg; the restart (counters cleared, LED lit
    // for FLASH/BURST) happens on the following edge. A phase pulse coinciding
    // with either of those two edges is ignored by this channel, so a
    // restarted channel always shows a lit first phase that ends at the next
    // shared phase boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q    <= LED_OFF;
            arg_q     <= '0;
            state_q   <= B_ON;
            blink_q   <= '0;
            gap_q     <= '0;
            restart_q <= 1'b0;
            led_q     <= 1'b0;
        end else if (i_we) begin
            mode_q    <= led_mode_e'(i_mode);
            arg_q     <= i_arg;
            restart_q <= 1'b1;
        end else if (restart_q) begin
            restart_q <= 1'b0;
            state_q   <= B_ON;
            blink_q   <= '0;
            gap_q     <= '0;
            led_q     <= (mode_q != LED_OFF);
        end else begin
            case (mode_q)
                LED_OFF:   led_q <= 1'b0;
                LED_ON:    led_q <= 1'b1;
                LED_FLASH: begin
                    if (i_phase) begin
                        led_q <= ~led_q;
                    end
                end
                LED_BURST: begin
                    if (i_phase) begin
                        case (state_q)
                            B_ON: begin
                                state_q <= B_OFF;
                                led_q   <= 1'b0;
                            end
                            B_OFF: begin
                                if (burst_done) begin
                                    state_q <= B_GAP;
                                    blink_q <= '0;
                                    led_q   <= 1'b0;
                                end else begin
                                    state_q <= B_ON;
                                    blink_q <= blink_d;
                                    led_q   <= 1'b1;
                                end
                            end
                            B_GAP: begin
                                if (gap_done) begin
                                    state_q <= B_ON;
                                    gap_q   <= '0;
                                    led_q   <= 1'b1;
                                end else begin
                                    gap_q <= gap_d;
                                    led_q <= 1'b0;
                                end
                            end
                            default: begin
                                state_q <= B_ON;
                                led_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                default: led_q <= 1'b0;
            endcase
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/led_bank_ctrl.sv
// -----------------------------------------------------------------------------
// led_bank_ctrl
// Multi-channel LED driver. A shared prescaler and phase counter produce a
// common phase pulse; each channel (led_channel) turns it into its own
// OFF / ON / FLASH / BURST pattern, so all channels stay phase-aligned.
//
// Ports:
//   i_clk       - system clock (only clock)
//   i_rst_n     - asynchronous active-low reset
//   i_divider   - prescaler terminal count; one tick every i_divider+1 clocks
//   i_cfg_we    - configuration write strobe, one write per asserted cycle
//   i_cfg_sel   - channel to write; values >= NUM_LEDS are ignored
//   i_cfg_mode  - 0 OFF, 1 ON, 2 FLASH, 3 BURST
//   i_cfg_arg   - blinks per burst (BURST only, 0 treated as 1)
//   o_led       - registered LED drives, active-high
//   o_phase     - registered one-cycle pulse per phase boundary
// -----------------------------------------------------------------------------
module led_bank_ctrl
    import led_pkg::*;
#(
    parameter int          NUM_LEDS   = 4,
    parameter int          DIV_W      = 8,
    parameter int unsigned PERIOD     = LED_PERIOD_DEFAULT,
    parameter int          BURST_W    = 4,
    parameter int          GAP_PHASES = 4,
    // Derived; not meant to be overridden.
    parameter int          SEL_W      = sel_width(NUM_LEDS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DIV_W-1:0]    i_divider,
    input  logic                i_cfg_we,
    input  logic [SEL_W-1:0]    i_cfg_sel,
    input  logic [1:0]          i_cfg_mode,
    input  logic [BURST_W-1:0]  i_cfg_arg,
    output logic [NUM_LEDS-1:0] o_led,
    output logic                o_phase
);

    localparam logic [31:0] PH_LAST = 32'(PERIOD - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      ph_cnt_q,  ph_cnt_d;
    logic             phase_q,   phase_d;
    logic             tick;

    // Prescaler and phase counter. If the divider is lowered below the
    // current count, the prescaler restarts from zero without ticking.
    always_comb begin
        tick      = 1'b0;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q > i_divider) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == i_divider) begin
            tick      = 1'b1;
            div_cnt_d = '0;
        end

        ph_cnt_d = ph_cnt_q;
        phase_d  = 1'b0;
        if (tick) begin
            if (ph_cnt_q == PH_LAST) begin
                ph_cnt_d = '0;
                phase_d  = 1'b1;
            end else begin
                ph_cnt_d = ph_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= '0;
            ph_cnt_q  <= '0;
            phase_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ph_cnt_q  <= ph_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign o_phase = phase_q;

    // Channels consume the registered pulse, so an LED changes on the edge
    // that ends the cycle in which o_phase is high.
    logic [NUM_LEDS-1:0] ch_we;

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            // Out-of-range selects match no channel and are dropped here.
            assign ch_we[gi] = i_cfg_we && (i_cfg_sel == SEL_W'(gi));

            led_channel #(
                .BURST_W    (BURST_W),
                .GAP_PHASES (GAP_PHASES)
            ) u_ch (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_phase (phase_q),
                .i_we    (ch_we[gi]),
                .i_mode  (i_cfg_mode),
                .i_arg   (i_cfg_arg),
                .o_led   (o_led[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_bank_ctrl
// Bench for led_bank_ctrl (NUM_LEDS=4, PERIOD=4, GAP_PHASES=4) plus a small
// 3-channel instance used for out-of-range channel selects.
// -----------------------------------------------------------------------------
module tb_led_bank_ctrl;

    localparam int NL  = 4;
    localparam int DW  = 8;
    localparam int PER = 4;
    localparam int BW  = 4;
    localparam int GP  = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [DW-1:0] divider  = 8'd1;
    logic          cfg_we   = 1'b0;
    logic [1:0]    cfg_sel  = 2'd0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [BW-1:0] cfg_arg  = '0;
    logic [NL-1:0] o_led;
    logic          o_phase;

    logic          we2  = 1'b0;
    logic [1:0]    sel2 = 2'd0;
    logic [2:0]    led2;
    logic          phase2;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    led_bank_ctrl #(
        .NUM_LEDS(NL), .DIV_W(DW), .PERIOD(PER), .BURST_W(BW), .GAP_PHASES(GP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_divider(divider),
        .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_mode(cfg_mode),
        .i_cfg_arg(cfg_arg), .o_led(o_led), .o_phase(o_phase)
    );

    led_bank_ctrl #(
        .NUM_LEDS(3), .DIV_W(DW), .PERIOD(PER), .BURST_W(BW), .GAP_PHASES(GP)
    ) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_divider(divider),
        .i_cfg_we(we2), .i_cfg_sel(sel2), .i_cfg_mode(cfg_mode),
        .i_cfg_arg(cfg_arg), .o_led(led2), .o_phase(phase2)
    );

    // ---------------- behavioural model ----------------
    // Each channel is described by its mode, its argument and the number of
    // phases elapsed since it restarted; the LED level is a closed-form
    // function of those.
    function automatic logic led_of(input int mode, input int arg, input int n);
        int a;
        int len;
        int p;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (n % 2) == 0;
            default: begin
                a   = (arg == 0) ? 1 : arg;
                len = 2 * a + GP;
                p   = n % len;
                return (p < 2 * a) && ((p % 2) == 0);
            end
        endcase
    endfunction

    int   m_div, m_ph;
    logic m_phase;
    int   m_mode [NL];
    int   m_arg  [NL];
    int   m_n    [NL];
    logic m_pend [NL];
    logic m_led  [NL];
    logic m_over, m_tick;
    logic [NL-1:0] exp_led;

    assign m_over = m_div > int'(divider);
    assign m_tick = !m_over && (m_div == int'(divider));

    always_comb begin
        exp_led = '0;
        for (int k = 0; k < NL; k++) exp_led[k] = m_led[k];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div   <= 0;
            m_ph    <= 0;
            m_phase <= 1'b0;
            for (int k = 0; k < NL; k++) begin
                m_mode[k] <= 0;
                m_arg[k]  <= 0;
                m_n[k]    <= 0;
                m_pend[k] <= 1'b0;
                m_led[k]  <= 1'b0;
            end
        end else begin
            m_div <= (m_over || m_tick) ? 0 : m_div + 1;
            if (m_tick && m_ph == PER - 1) begin
                m_ph    <= 0;
                m_phase <= 1'b1;
            end else begin
                m_phase <= 1'b0;
                if (m_tick) m_ph <= m_ph + 1;
            end
            for (int k = 0; k < NL; k++) begin
                if (cfg_we && int'(cfg_sel) == k) begin
                    m_mode[k] <= int'(cfg_mode);
                    m_arg[k]  <= int'(cfg_arg);
                    m_pend[k] <= 1'b1;
                end else if (m_pend[k]) begin
                    m_pend[k] <= 1'b0;
                    m_n[k]    <= 0;
                    m_led[k]  <= led_of(m_mode[k], m_arg[k], 0);
                end else if (m_phase && m_mode[k] >= 2) begin
                    m_n[k]   <= m_n[k] + 1;
                    m_led[k] <= led_of(m_mode[k], m_arg[k], m_n[k] + 1);
                end else begin
                    m_led[k] <= led_of(m_mode[k], m_arg[k], m_n[k]);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if ({o_phase, o_led} !== {m_phase, exp_led}) begin
                    n_fail++;
                    $display("FAIL per_cycle t=%0t: o_phase/o_led got %b/%b required %b/%b",
                             $time, o_phase, o_led, m_phase, exp_led);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_phase();
        int n = 0;
        while (!o_phase && n < 200) begin
            step(1);
            n++;
        end
        if (!o_phase) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_phase: o_phase got 0 required 1 within %0d cycles", n);
        end
    endtask

    task automatic phase_gap(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!o_phase && n < 200);
    endtask

    task automatic cfg_write(input int sel, input int mode, input int arg);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_mode = 2'(mode);
        cfg_arg  = BW'(arg);
        step(1);
        cfg_we   = 1'b0;
        $display("write sel=%0d mode=%0d arg=%0d at t=%0t", sel, mode, arg, $time);
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] exp_b2;
    logic [11:0] exp_b0;
    int g;

    initial begin
        // Reset held with a write pending: nothing must take effect.
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_mode = 2'd1;
        we2 = 1'b1; sel2 = 2'd0;
        step(3);
        chk_en = 1'b1;
        check("reset_led", 32'(o_led), 32'd0);
        check("reset_phase", 32'(o_phase), 32'd0);
        check("reset_small_led", 32'(led2), 32'd0);
        step(2);
        check("reset_hold_led", 32'(o_led), 32'd0);
        cfg_we = 1'b0; we2 = 1'b0;
        rst_n = 1'b1;
        step(3);
        check("post_reset_no_write", 32'(o_led), 32'd0);

        // Timebase: divider=1, PERIOD=4 -> 8 clocks per phase.
        wait_phase();
        phase_gap(g); check("phase_len_div1_a", 32'(g), 32'd8);
        phase_gap(g); check("phase_len_div1_b", 32'(g), 32'd8);
        // One cycle after the pulse the prescaler count is 1; dropping the
        // divider to 0 restarts it without a tick: 5 cycles, then 4 each.
        step(1);
        divider = 8'd0;
        $display("divider set to 0 at t=%0t", $time);
        phase_gap(g); check("phase_len_div_change", 32'(g), 32'd5);
        phase_gap(g); check("phase_len_div0_a", 32'(g), 32'd4);
        phase_gap(g); check("phase_len_div0_b", 32'(g), 32'd4);
        divider = 8'd1;
        $display("divider set to 1 at t=%0t", $time);
        phase_gap(g); check("phase_len_div1_c", 32'(g), 32'd8);

        // FLASH on ch0.
        wait_phase();
        step(2);
        cfg_write(0, 2, 0);
        check("flash_edge_n", 32'(o_led), 32'd0);
        step(1);
        check("flash_edge_n1", 32'(o_led), 32'b0001);
        wait_phase(); step(1); check("flash_toggle_1", 32'(o_led[0]), 32'd0);
        wait_phase(); step(1); check("flash_toggle_2", 32'(o_led[0]), 32'd1);
        wait_phase(); step(1); check("flash_toggle_3", 32'(o_led[0]), 32'd0);
        check("flash_others_dark", 32'(o_led[3:1]), 32'd0);

        // BURST arg=2 on ch1: 1,0,1,0,0,0,0,0 per phase.
        exp_b2 = 16'b0000_0101_0000_0101;
        wait_phase();
        step(2);
        cfg_write(1, 3, 2);
        step(1);
        check("burst2_p0", 32'(o_led[1]), 32'(exp_b2[0]));
        for (int i = 1; i < 16; i++) begin
            wait_phase();
            step(1);
            check($sformatf("burst2_p%0d", i), 32'(o_led[1]), 32'(exp_b2[i]));
        end

        // BURST arg=0 on ch3: behaves as arg=1 -> 1,0,0,0,0,0.
        exp_b0 = 12'b0000_0100_0001;
        wait_phase();
        step(2);
        cfg_write(3, 3, 0);
        step(1);
        check("burst0_p0", 32'(o_led[3]), 32'(exp_b0[0]));
        for (int i = 1; i < 12; i++) begin
            wait_phase();
            step(1);
            check($sformatf("burst0_p%0d", i), 32'(o_led[3]), 32'(exp_b0[i]));
        end

        // Collision: ch2 FLASH lit, write ON in the pulse cycle -> no toggle.
        wait_phase();
        step(2);
        cfg_write(2, 2, 0);
        g = 0;
        while (!(o_phase && o_led[2]) && g < 200) begin
            step(1);
            g++;
        end
        check("collision_setup", 32'({o_phase, o_led[2]}), 32'b11);
        cfg_write(2, 1, 0);
        check("collision_edge_n", 32'(o_led[2]), 32'd1);
        step(1);
        check("collision_edge_n1", 32'(o_led[2]), 32'd1);

        // Out-of-range select on the 3-channel instance is ignored.
        cfg_mode = 2'd1;
        we2 = 1'b1; sel2 = 2'd3;
        step(1);
        we2 = 1'b0;
        $display("small write sel=3 mode=1 at t=%0t", $time);
        step(2);
        check("oor_sel_ignored", 32'(led2), 32'd0);
        we2 = 1'b1; sel2 = 2'd2;
        step(1);
        we2 = 1'b0;
        $display("small write sel=2 mode=1 at t=%0t", $time);
        step(1);
        check("small_sel2_on", 32'(led2), 32'b100);

        // Async reset while ch1 sits in its burst gap.
        wait_phase();
        step(2);
        cfg_write(1, 3, 2);
        step(1);
        for (int i = 0; i < 4; i++) begin
            wait_phase();
            step(1);
        end
        check("pre_reset_gap_dark", 32'(o_led[1]), 32'd0);
        check("pre_reset_ch2_on", 32'(o_led[2]), 32'd1);
        step(1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_led", 32'(o_led), 32'd0);
        check("async_reset_phase", 32'(o_phase), 32'd0);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_mode = 2'd1;
        @(posedge clk);
        #2;
        step(2);
        cfg_we = 1'b0;
        rst_n = 1'b1;
        step(4);
        check("post_async_all_off", 32'(o_led), 32'd0);
        cfg_write(0, 2, 0);
        step(1);
        check("post_async_flash", 32'(o_led), 32'b0001);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
